// File: rtl/freq_div_multi.sv
// freq_div_multi: multi-channel programmable clock-enable / square-wave generator.
//
// Every channel has a free-running counter that wraps at a runtime-writable
// terminal count ("active" limit). On wrap it emits a one-cycle tick and
// toggles its square wave. New limits land in a shadow register and are
// transferred at the next period boundary, so periods are never truncated.
//
// Optional macro FREQ_DIV_DUTY_EN: adds port limit_hi and a double-buffered
// per-channel hi threshold. signal becomes PWM (high while next cnt < hi).
//
// Ports:
//   clk        global clock, posedge
//   rst        synchronous active-high reset
//   en         [CH]     per-channel count enable
//   sync_clr   phase-align all channels (cnt/signal/tick to 0, flush shadows)
//   limit_wr   write strobe for the shadow limit of channel limit_sel
//   limit_sel  [SEL_W]  target channel; values >= CH are ignored
//   limit_data [CNT_W]  new terminal count
//   limit_hi   [CNT_W]  new PWM threshold (FREQ_DIV_DUTY_EN only)
//   signal     [CH]     registered square-wave / PWM outputs
//   tick       [CH]     registered terminal-count pulses
//   pending    [CH]     shadow written but not yet active

module freq_div_ch #(
  parameter int CNT_W         = 27,
  parameter int DEFAULT_LIMIT = 49999999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             wr,
  input  logic [CNT_W-1:0] wdata,
`ifdef FREQ_DIV_DUTY_EN
  input  logic [CNT_W-1:0] wdata_hi,
`endif
  output logic             signal,
  output logic             tick,
  output logic             pending
);
  localparam logic [CNT_W-1:0] DEF_LIM = CNT_W'(DEFAULT_LIMIT);

  logic [CNT_W-1:0] cnt, active, shadow, cnt_nx;
  logic             tc;

  assign tc     = (cnt == active);
  assign cnt_nx = tc ? '0 : cnt + CNT_W'(1);

`ifdef FREQ_DIV_DUTY_EN
  localparam logic [CNT_W-1:0] DEF_HI = CNT_W'((DEFAULT_LIMIT + 1) / 2);
  logic [CNT_W-1:0] hi_act, hi_shd, hi_nx;

  // Threshold that governs the period starting after this edge.
  always_comb begin
    hi_nx = hi_act;
    if (tc) begin
      if (wr)           hi_nx = wdata_hi;
      else if (pending) hi_nx = hi_shd;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      active  <= DEF_LIM;
      shadow  <= DEF_LIM;
      pending <= 1'b0;
      signal  <= 1'b0;
      tick    <= 1'b0;
`ifdef FREQ_DIV_DUTY_EN
      hi_act  <= DEF_HI;
      hi_shd  <= DEF_HI;
`endif
    end else if (clr) begin
      // Phase align; any queued limit becomes active, same-cycle writes dropped.
      cnt     <= '0;
      signal  <= 1'b0;
      tick    <= 1'b0;
      pending <= 1'b0;
      if (pending) begin
        active <= shadow;
`ifdef FREQ_DIV_DUTY_EN
        hi_act <= hi_shd;
`endif
      end
    end else if (en) begin
      cnt  <= cnt_nx;
      tick <= tc;
`ifdef FREQ_DIV_DUTY_EN
      signal <= (cnt_nx < hi_nx);
`else
      if (tc) signal <= ~signal;
`endif
      if (tc) begin
        // A write landing on the wrap cycle goes straight to active.
        if (wr) begin
          active  <= wdata;
          shadow  <= wdata;
          pending <= 1'b0;
`ifdef FREQ_DIV_DUTY_EN
          hi_act  <= wdata_hi;
          hi_shd  <= wdata_hi;
`endif
        end else if (pending) begin
          active  <= shadow;
          pending <= 1'b0;
`ifdef FREQ_DIV_DUTY_EN
          hi_act  <= hi_shd;
`endif
        end
      end else if (wr) begin
        shadow  <= wdata;
        pending <= 1'b1;
`ifdef FREQ_DIV_DUTY_EN
        hi_shd  <= wdata_hi;
`endif
      end
    end else begin
      // Frozen channel: counter/signal hold, writes still queue.
      tick <= 1'b0;
      if (wr) begin
        shadow  <= wdata;
        pending <= 1'b1;
`ifdef FREQ_DIV_DUTY_EN
        hi_shd  <= wdata_hi;
`endif
      end
    end
  end
endmodule

module freq_div_multi #(
  parameter int CH            = 4,
  parameter int CNT_W         = 27,
  parameter int DEFAULT_LIMIT = 49999999,
  parameter int SEL_W         = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH-1:0]    en,
  input  logic             sync_clr,
  input  logic             limit_wr,
  input  logic [SEL_W-1:0] limit_sel,
  input  logic [CNT_W-1:0] limit_data,
`ifdef FREQ_DIV_DUTY_EN
  input  logic [CNT_W-1:0] limit_hi,
`endif
  output logic [CH-1:0]    signal,
  output logic [CH-1:0]    tick,
  output logic [CH-1:0]    pending
);
  logic [CH-1:0] wr_ch;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    // Out-of-range selects match no channel, so such writes vanish.
    assign wr_ch[i] = limit_wr && (32'(limit_sel) == i);

    freq_div_ch #(
      .CNT_W        (CNT_W),
      .DEFAULT_LIMIT(DEFAULT_LIMIT)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en[i]),
      .clr     (sync_clr),
      .wr      (wr_ch[i]),
      .wdata   (limit_data),
`ifdef FREQ_DIV_DUTY_EN
      .wdata_hi(limit_hi),
`endif
      .signal  (signal[i]),
      .tick    (tick[i]),
      .pending (pending[i])
    );
  end
endmodule

// File: tb/tb_freq_div_multi.sv
// Randomized + directed bench for freq_div_multi with a queue scoreboard.
// Stimulus is driven on negedge and the model's expected outputs are pushed;
// a monitor pops one entry per posedge and compares the registered outputs.
module tb_freq_div_multi;
  localparam int CH    = 4;
  localparam int CNT_W = 8;
  localparam int DEF   = 3;
  localparam int SEL_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [CH-1:0]    en = '0;
  logic             sync_clr = 1'b0;
  logic             limit_wr = 1'b0;
  logic [SEL_W-1:0] limit_sel = '0;
  logic [CNT_W-1:0] limit_data = '0;
`ifdef FREQ_DIV_DUTY_EN
  logic [CNT_W-1:0] limit_hi = '0;
`endif
  logic [CH-1:0]    signal, tick, pending;

  always #5 clk = ~clk;

  freq_div_multi #(.CH(CH), .CNT_W(CNT_W), .DEFAULT_LIMIT(DEF), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst(rst), .en(en), .sync_clr(sync_clr), .limit_wr(limit_wr),
    .limit_sel(limit_sel), .limit_data(limit_data),
`ifdef FREQ_DIV_DUTY_EN
    .limit_hi(limit_hi),
`endif
    .signal(signal), .tick(tick), .pending(pending));

  typedef struct packed {
    logic [CH-1:0] sig;
    logic [CH-1:0] tck;
    logic [CH-1:0] pnd;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   errors  = 0;

  // Reference model: per-channel position within the current period plus limits.
  int unsigned   m_pos[CH], m_lim[CH], m_nlim[CH], m_hi[CH], m_nhi[CH];
  bit [CH-1:0]   m_sig, m_tck, m_pnd;

  task automatic step(input bit r, input bit [CH-1:0] e, input bit c,
                      input bit w, input int sel, input int d, input int h);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; sync_clr = c; limit_wr = w;
    limit_sel = SEL_W'(sel); limit_data = CNT_W'(d);
`ifdef FREQ_DIV_DUTY_EN
    limit_hi = CNT_W'(h);
`endif
    for (int i = 0; i < CH; i++) begin
      bit hit;
      hit = w && (sel == i);
      if (r) begin
        m_pos[i] = 0; m_lim[i] = DEF; m_nlim[i] = DEF;
        m_hi[i] = (DEF + 1) / 2; m_nhi[i] = (DEF + 1) / 2;
        m_sig[i] = 0; m_tck[i] = 0; m_pnd[i] = 0;
      end else if (c) begin
        if (m_pnd[i]) begin m_lim[i] = m_nlim[i]; m_hi[i] = m_nhi[i]; end
        m_pnd[i] = 0; m_pos[i] = 0; m_sig[i] = 0; m_tck[i] = 0;
      end else if (e[i]) begin
        if (m_pos[i] == m_lim[i]) begin
          m_pos[i] = 0; m_tck[i] = 1; m_sig[i] = ~m_sig[i];
          if (hit) begin
            m_lim[i] = d; m_nlim[i] = d; m_hi[i] = h; m_nhi[i] = h; m_pnd[i] = 0;
          end else if (m_pnd[i]) begin
            m_lim[i] = m_nlim[i]; m_hi[i] = m_nhi[i]; m_pnd[i] = 0;
          end
        end else begin
          m_pos[i]++; m_tck[i] = 0;
          if (hit) begin m_nlim[i] = d; m_nhi[i] = h; m_pnd[i] = 1; end
        end
`ifdef FREQ_DIV_DUTY_EN
        m_sig[i] = (m_pos[i] < m_hi[i]);
`endif
      end else begin
        m_tck[i] = 0;
        if (hit) begin m_nlim[i] = d; m_nhi[i] = h; m_pnd[i] = 1; end
      end
    end
    x.sig = m_sig; x.tck = m_tck; x.pnd = m_pnd;
    q.push_back(x);
  endtask

  task automatic run(input int n, input bit [CH-1:0] e);
    for (int k = 0; k < n; k++) step(0, e, 0, 0, 0, 0, 0);
  endtask

  // Monitor: one registered result per clock edge.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      vectors++;
      if ({signal, tick, pending} !== {x.sig, x.tck, x.pnd}) begin
        errors++;
        $display("FAIL outputs t=%0t sig=%b/%b tick=%b/%b pend=%b/%b (actual/required)",
                 $time, signal, x.sig, tick, x.tck, pending, x.pnd);
      end
    end
  end

  initial begin
    int lim;
    // Reset and single-channel divide-by-4 run.
    step(1, '0, 0, 0, 0, 0, 0);
    step(1, '0, 0, 0, 0, 0, 0);
    run(16, 4'b0001);

    // ch1 -> limit 5, then a shorter limit written mid-period.
    step(0, 4'b1111, 0, 1, 1, 5, 2);
    run(8, 4'b1111);
    for (int k = 0; k < 20 && m_pos[1] != 2; k++) run(1, 4'b1111);
    step(0, 4'b1111, 0, 1, 1, 1, 1);
    run(12, 4'b1111);

    // Write coinciding with ch2 terminal count, limit 0.
    for (int k = 0; k < 20 && m_pos[2] != m_lim[2]; k++) run(1, 4'b1111);
    step(0, 4'b1111, 0, 1, 2, 0, 0);
    run(6, 4'b1111);

    // Freeze ch3 with a pending write, then resume.
    run(2, 4'b1111);
    step(0, 4'b0111, 0, 1, 3, 6, 3);
    run(10, 4'b0111);
    run(12, 4'b1111);

    // Phase align ch0 (limit 3) and ch1 (limit 7); write in same cycle dropped.
    step(1, '0, 0, 0, 0, 0, 0);
    step(0, 4'b0011, 0, 1, 1, 7, 4);
    run(5, 4'b0011);
    step(0, 4'b0011, 1, 1, 0, 9, 9);
    run(20, 4'b0011);

    // Out-of-range write, then reset mid-period.
    step(0, 4'b1111, 0, 1, CH, 1, 1);
    run(3, 4'b1111);
    step(1, 4'b1111, 0, 0, 0, 0, 0);
    run(4, 4'b1111);

    // PWM-style pattern: limit 9, hi 3 on ch0 (plain toggle without the macro).
    step(0, 4'b0001, 1, 0, 0, 0, 0);
    step(0, 4'b0001, 0, 1, 0, 9, 3);
    run(30, 4'b0001);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      bit r, c, w;
      r = ($urandom_range(0, 299) == 0);
      c = ($urandom_range(0, 59) == 0);
      w = ($urandom_range(0, 7) == 0);
      lim = $urandom_range(0, 12);
      step(r, CH'($urandom) | CH'($urandom), c, w, $urandom_range(0, 7),
           lim, $urandom_range(0, 14));
    end

    // Drain scoreboard with a bound.
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain remaining=%0d required=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
